// File: rtl/epd_tx.sv
// epd_tx: byte-wide Ethernet frame generator feeding the epd receive path.
// Emits preamble, SFD, header, payload, pad and FCS, then an idle gap.
module epd_tx #(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_PAYLOAD  = 46,
  parameter int MAX_PAYLOAD  = 1500,
  parameter int IFG_LEN      = 12
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [47:0] dst_addr,
  input  logic [47:0] src_addr,
  input  logic [15:0] type_length,
  input  logic [7:0]  pl_data,
  input  logic        pl_valid,
  input  logic        pl_last,
  output logic        pl_ready,
  output logic [7:0]  data,
  output logic        control,
  output logic        busy,
  output logic        tx_underrun,
  output logic [3:0]  tx_packet_counter
);

  typedef enum logic [3:0] {
    IDLE, PREAMBLE, SFD, DST, SRC, TL,
    PAYLOAD, PAD, FCS, IFG
  } state_t;

  localparam logic [10:0] PRE_END = 11'(PREAMBLE_LEN - 1);
  localparam logic [10:0] MIN_LEN = 11'(MIN_PAYLOAD);
  localparam logic [10:0] MAX_END = 11'(MAX_PAYLOAD - 1);
  localparam logic [10:0] IFG_END = 11'(IFG_LEN);

  state_t       state_q, state_d;
  logic [10:0]  cnt_q, cnt_d;
  logic [111:0] hdr_q, hdr_d;
  logic [31:0]  crc_q, crc_d;
  logic [7:0]   data_q, data_d;
  logic         control_q, control_d;
  logic         underrun_q, underrun_d;
  logic         done_q, done_d;
  logic [3:0]   pkt_q, pkt_d;

  function automatic logic [31:0] crc_step(
    input logic [31:0] c,
    input logic [7:0]  b
  );
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r >> 1) ^ ((r[0] ^ b[i]) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hdr_d      = hdr_q;
    crc_d      = crc_q;
    data_d     = 8'h00;
    control_d  = 1'b0;
    underrun_d = 1'b0;
    done_d     = 1'b0;
    pkt_d      = pkt_q + {3'b000, done_q};
    unique case (state_q)
      IDLE: begin
        if (start) begin
          hdr_d   = {dst_addr, src_addr, type_length};
          crc_d   = '1;
          cnt_d   = '0;
          state_d = PREAMBLE;
        end
      end
      PREAMBLE: begin
        data_d    = 8'h55;
        control_d = 1'b1;
        cnt_d     = cnt_q + 11'd1;
        if (cnt_q == PRE_END) begin
          cnt_d   = '0;
          state_d = SFD;
        end
      end
      SFD: begin
        data_d    = 8'hD5;
        control_d = 1'b1;
        cnt_d     = '0;
        state_d   = DST;
      end
      DST, SRC, TL: begin
        data_d    = hdr_q[111:104];
        control_d = 1'b1;
        hdr_d     = {hdr_q[103:0], 8'h00};
        crc_d     = crc_step(crc_q, data_d);
        cnt_d     = cnt_q + 11'd1;
        if (state_q == TL) begin
          if (cnt_q == 11'd1) begin
            cnt_d   = '0;
            state_d = PAYLOAD;
          end
        end else if (cnt_q == 11'd5) begin
          cnt_d   = '0;
          state_d = (state_q == DST) ? SRC : TL;
        end
      end
      PAYLOAD: begin
        // A missing byte cannot be stalled over: abort into the gap.
        if (!pl_valid) begin
          underrun_d = 1'b1;
          cnt_d      = 11'd1;
          state_d    = IFG;
        end else begin
          data_d    = pl_data;
          control_d = 1'b1;
          crc_d     = crc_step(crc_q, data_d);
          cnt_d     = cnt_q + 11'd1;
          if (pl_last || cnt_q == MAX_END) begin
            if (cnt_d < MIN_LEN) begin
              state_d = PAD;
            end else begin
              cnt_d   = '0;
              state_d = FCS;
            end
          end
        end
      end
      PAD: begin
        control_d = 1'b1;
        crc_d     = crc_step(crc_q, data_d);
        cnt_d     = cnt_q + 11'd1;
        if (cnt_q == MIN_LEN - 11'd1) begin
          cnt_d   = '0;
          state_d = FCS;
        end
      end
      FCS: begin
        data_d    = 8'(~crc_q >> {cnt_q[1:0], 3'b000});
        control_d = 1'b1;
        cnt_d     = cnt_q + 11'd1;
        if (cnt_q == 11'd3) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = IFG;
        end
      end
      IFG: begin
        cnt_d = cnt_q + 11'd1;
        if (cnt_q == IFG_END) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hdr_q      <= '0;
      crc_q      <= '1;
      data_q     <= '0;
      control_q  <= 1'b0;
      underrun_q <= 1'b0;
      done_q     <= 1'b0;
      pkt_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hdr_q      <= hdr_d;
      crc_q      <= crc_d;
      data_q     <= data_d;
      control_q  <= control_d;
      underrun_q <= underrun_d;
      done_q     <= done_d;
      pkt_q      <= pkt_d;
    end
  end

  assign pl_ready          = (state_q == PAYLOAD);
  assign busy              = (state_q != IDLE);
  assign data              = data_q;
  assign control           = control_q;
  assign tx_underrun       = underrun_q;
  assign tx_packet_counter = pkt_q;

endmodule

// File: tb/tb_epd_tx.sv
// tb_epd_tx: directed frames into epd_tx, checked against a software
// frame and CRC-32 model.
module tb_epd_tx;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [47:0] dst_addr;
  logic [47:0] src_addr;
  logic [15:0] type_length;
  logic [7:0]  pl_data;
  logic        pl_valid;
  logic        pl_last;
  logic        pl_ready;
  logic [7:0]  data;
  logic        control;
  logic        busy;
  logic        tx_underrun;
  logic [3:0]  tx_packet_counter;

  epd_tx dut (
    .clock             (clock),
    .reset             (reset),
    .start             (start),
    .dst_addr          (dst_addr),
    .src_addr          (src_addr),
    .type_length       (type_length),
    .pl_data           (pl_data),
    .pl_valid          (pl_valid),
    .pl_last           (pl_last),
    .pl_ready          (pl_ready),
    .data              (data),
    .control           (control),
    .busy              (busy),
    .tx_underrun       (tx_underrun),
    .tx_packet_counter (tx_packet_counter)
  );

  always #5 clock = ~clock;

  int         n_chk = 0;
  int         n_err = 0;
  logic [7:0] pl_mem [0:1599];
  logic [7:0] got_q [$];
  logic [7:0] exp_q [$];
  int         ctl_cnt, runs, ifg_cnt, unr_cnt, xfers, lat, fall_cnt;
  logic [3:0] cnt_exp;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_model(input logic [31:0] c,
                                            input logic [7:0] b);
    c = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++)
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  task automatic build_exp(input logic [47:0] d, input logic [47:0] s,
                           input logic [15:0] t, input int n,
                           input bit full);
    logic [31:0] crc;
    int          first;
    exp_q.delete();
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    first = exp_q.size();
    for (int i = 5; i >= 0; i--) exp_q.push_back(d[8*i +: 8]);
    for (int i = 5; i >= 0; i--) exp_q.push_back(s[8*i +: 8]);
    exp_q.push_back(t[15:8]);
    exp_q.push_back(t[7:0]);
    for (int i = 0; i < n; i++) exp_q.push_back(pl_mem[i]);
    if (full) begin
      for (int i = n; i < 46; i++) exp_q.push_back(8'h00);
      crc = 32'hFFFFFFFF;
      for (int i = first; i < exp_q.size(); i++)
        crc = crc_model(crc, exp_q[i]);
      crc = ~crc;
      for (int i = 0; i < 4; i++) exp_q.push_back(crc[8*i +: 8]);
    end
  endtask

  // Entered at a negedge with busy=0; returns at the negedge busy drops.
  task automatic run_frame(input logic [47:0] d, input logic [47:0] s,
                           input logic [15:0] t, input int n_offer,
                           input bit with_last, input int stop_at,
                           input bit hold);
    int idx, cyc;
    bit prev_ctl;
    got_q.delete();
    ctl_cnt = 0; runs = 0; ifg_cnt = 0; unr_cnt = 0;
    xfers = 0; lat = -1; fall_cnt = -1;
    idx = 0; cyc = 0; prev_ctl = 1'b0;
    dst_addr = d; src_addr = s; type_length = t;
    start = 1'b1;
    pl_valid = 1'b0; pl_last = 1'b0; pl_data = 8'h00;
    forever begin
      @(negedge clock);
      cyc++;
      if (!hold) start = 1'b0;
      dst_addr = ~d; src_addr = ~s; type_length = ~t;
      if (tx_underrun) unr_cnt++;
      if (control) begin
        got_q.push_back(data);
        ctl_cnt++;
        if (!prev_ctl) runs++;
        if (lat < 0) lat = cyc;
      end else if (busy && (ctl_cnt > 0 || unr_cnt > 0)) begin
        ifg_cnt++;
      end
      if (prev_ctl && !control && fall_cnt < 0)
        fall_cnt = int'(tx_packet_counter);
      prev_ctl = control;
      if (!busy) break;
      if (cyc > 4000) begin
        n_chk++; n_err++;
        $display("FAIL timeout: busy still %0b after %0d cycles", busy, cyc);
        break;
      end
      pl_valid = (idx < n_offer) && (idx != stop_at);
      pl_data  = (idx < n_offer) ? pl_mem[idx] : 8'h00;
      pl_last  = with_last && (idx == n_offer - 1);
      if (pl_ready && pl_valid) begin
        xfers++;
        idx++;
      end
    end
    pl_valid = 1'b0;
    pl_last  = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int exp_len,
                             input int exp_xfers, input int exp_unr);
    int nbad;
    int n;
    nbad = 0;
    chk({tag, "_len"}, ctl_cnt, exp_len);
    chk({tag, "_xfers"}, xfers, exp_xfers);
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) nbad++;
    chk({tag, "_bytes"}, nbad, 0);
    chk({tag, "_runs"}, runs, 1);
    chk({tag, "_latency"}, lat, 2);
    chk({tag, "_ifg"}, ifg_cnt, 12);
    chk({tag, "_underrun"}, unr_cnt, exp_unr);
    chk({tag, "_cnt_fall"}, fall_cnt, {28'h0, cnt_exp});
    n = got_q.size();
    if (exp_unr == 0 && n >= 4)
      chk({tag, "_fcs"},
          {got_q[n-1], got_q[n-2], got_q[n-3], got_q[n-4]},
          {exp_q[n-1], exp_q[n-2], exp_q[n-3], exp_q[n-4]});
  endtask

  initial begin
    int ctl;
    int cyc;
    reset = 1'b1; start = 1'b0;
    dst_addr = '0; src_addr = '0; type_length = '0;
    pl_data = '0; pl_valid = 1'b0; pl_last = 1'b0;
    cnt_exp = 4'd0;
    repeat (3) @(negedge clock);
    chk("rst_data", data, 0);
    chk("rst_control", control, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", pl_ready, 0);
    chk("rst_underrun", tx_underrun, 0);
    chk("rst_counter", tx_packet_counter, 0);
    reset = 1'b0;

    for (int i = 0; i < 49; i++) pl_mem[i] = 8'h55;
    pl_mem[49] = 8'h56;
    build_exp(48'h010203040506, 48'hFFFEFDFCFBFA, 16'h0800, 50, 1);
    run_frame(48'h010203040506, 48'hFFFEFDFCFBFA, 16'h0800, 50, 1, -1, 0);
    cnt_exp++;
    check_frame("basic", 76, 50, 0);
    chk("basic_counter", tx_packet_counter, 1);

    for (int i = 0; i < 10; i++) pl_mem[i] = 8'(i + 1);
    build_exp(48'hA1A2A3A4A5A6, 48'h112233445566, 16'h002E, 10, 1);
    run_frame(48'hA1A2A3A4A5A6, 48'h112233445566, 16'h002E, 10, 1, -1, 0);
    cnt_exp++;
    check_frame("short", 72, 10, 0);

    for (int i = 0; i < 30; i++) pl_mem[i] = 8'(8'hA0 + i);
    build_exp(48'h0C0D0E0F1011, 48'h202122232425, 16'h86DD, 20, 0);
    run_frame(48'h0C0D0E0F1011, 48'h202122232425, 16'h86DD, 30, 1, 20, 0);
    check_frame("underrun", 42, 20, 1);
    chk("underrun_counter", tx_packet_counter, 2);

    for (int i = 0; i < 1600; i++) pl_mem[i] = 8'(i) ^ 8'h3C;
    build_exp(48'h5A5A5A5A5A5A, 48'h000000000001, 16'h88B5, 1500, 1);
    run_frame(48'h5A5A5A5A5A5A, 48'h000000000001, 16'h88B5, 1600, 0, -1, 0);
    cnt_exp++;
    check_frame("oversize", 1526, 1500, 0);

    dst_addr = 48'h0F0E0D0C0B0A; src_addr = 48'h123456789ABC;
    type_length = 16'h0800; start = 1'b1;
    ctl = 0; cyc = 0;
    while (ctl < 16 && cyc < 100) begin
      @(negedge clock);
      start = 1'b0;
      cyc++;
      if (control) ctl++;
    end
    chk("mrst_reach_src", ctl, 16);
    chk("mrst_src_byte", data, 8'h34);
    reset = 1'b1;
    @(negedge clock);
    chk("mrst_data", data, 0);
    chk("mrst_control", control, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_counter", tx_packet_counter, 0);
    reset = 1'b0;
    cnt_exp = 4'd0;
    for (int i = 0; i < 46; i++) pl_mem[i] = 8'(8'hC3 ^ i);
    build_exp(48'h0F0E0D0C0B0A, 48'h123456789ABC, 16'h0800, 46, 1);
    run_frame(48'h0F0E0D0C0B0A, 48'h123456789ABC, 16'h0800, 46, 1, -1, 0);
    cnt_exp++;
    check_frame("after_rst", 72, 46, 0);

    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    cnt_exp = 4'd0;
    for (int f = 0; f < 16; f++) begin
      pl_mem[0] = 8'(f);
      build_exp({40'h0A0B0C0D0E, 8'(f)}, 48'h665544332211, 16'h0101, 1, 1);
      run_frame({40'h0A0B0C0D0E, 8'(f)}, 48'h665544332211, 16'h0101,
                1, 1, -1, 1);
      cnt_exp++;
      check_frame($sformatf("b2b%0d", f), 72, 1, 0);
    end
    start = 1'b0;
    chk("b2b_wrap", tx_packet_counter, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/epd_tx.md
Name: epd_tx

Overview:
- Ethernet packet generator; the transmit-side counterpart of the packet detector (epd).
- Drives the same byte-wide `data`/`control` stream that epd consumes: preamble, SFD, DST, SRC, type/length, payload, zero-padding, CRC-32 FCS, then inter-frame gap.
- Header fields are latched on a start pulse. Payload bytes arrive over a valid/ready handshake from a frame buffer.
- Used to build full-system loopback benches (epd_tx -> epd) and as the TX path of the MAC.

Parameters:
- PREAMBLE_LEN, 7: number of 0x55 bytes before SFD (0xD5).
- MIN_PAYLOAD, 46: payload shorter than this is zero-padded up to it.
- MAX_PAYLOAD, 1500: payload is truncated at this many bytes.
- IFG_LEN, 12: idle cycles (control=0) after the last FCS byte; must be >= 1.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to send a frame; sampled only when busy=0.
- dst_addr  in  48  destination MAC; [47:40] sent first.
- src_addr  in  48  source MAC; [47:40] sent first.
- type_length  in  16  type/length; [15:8] sent first.
- pl_data  in  8  payload byte.
- pl_valid  in  1  pl_data valid.
- pl_last  in  1  marks the final payload byte.
- pl_ready  out  1  block accepts pl_data at this edge.
- data  out  8  registered TX byte.
- control  out  1  registered; 1 = frame byte, 0 = IFG/idle.
- busy  out  1  high from the cycle after accepted start through the last IFG cycle.
- tx_underrun  out  1  one-cycle pulse when a frame is aborted.
- tx_packet_counter  out  4  completed frames, wraps 15->0.

Behaviour:
- Reset, synchronous, at any time including mid-frame:
  - Next cycle: data=0x00, control=0, pl_ready=0, busy=0, tx_underrun=0, tx_packet_counter=0, state=IDLE.
  - The CRC register is reinitialised and the partial frame is dropped.
- State machine: IDLE -> PREAMBLE -> SFD -> DST -> SRC -> TL -> PAYLOAD -> PAD -> FCS -> IFG -> IDLE.
- IDLE:
  - Outputs data=0x00, control=0.
  - start=1 latches dst_addr, src_addr and type_length.
  - If start is accepted at edge k, the first 0x55 appears on data with control=1 after edge k+1.
  - start is ignored while busy=1.
- PREAMBLE: PREAMBLE_LEN cycles of data=0x55.
- SFD: one cycle of data=0xD5.
- DST: 6 bytes, MSB first.
- SRC: 6 bytes, MSB first.
- TL: 2 bytes, MSB first.
- Payload handshake:
  - pl_ready=1 during the cycle data shows the TL low byte, and during each PAYLOAD cycle until the transfer carrying pl_last (or the MAX_PAYLOAD-th transfer) completes.
  - A byte transferred at an edge (pl_valid & pl_ready) appears on data in the following cycle.
  - Payload cannot stall.
- Underrun: pl_ready=1 and pl_valid=0 at an edge aborts the frame.
  - Next cycle control=0, data=0x00, tx_underrun=1 for one cycle.
  - The block enters IFG and tx_packet_counter is unchanged.
- Truncation: after MAX_PAYLOAD transfers without pl_last, pl_ready drops and the frame continues normally. The source must discard the rest of the frame.
- PAD: if payload count N < MIN_PAYLOAD, (MIN_PAYLOAD - N) bytes of 0x00 follow the payload.
- FCS:
  - IEEE 802.3 CRC-32: reflected polynomial 0xEDB88320, init 0xFFFFFFFF, final complement.
  - Covers DST through the last pad byte.
  - Sent as 4 bytes, crc[7:0] first.
- Frame length: control is high for exactly PREAMBLE_LEN + 1 + 14 + max(N, MIN_PAYLOAD) + 4 cycles, with no gaps.
- IFG: IFG_LEN cycles of control=0, data=0x00, busy=1, then IDLE. The earliest next start is accepted in the first IDLE cycle.
- Counter: tx_packet_counter increments in the cycle after the last FCS byte, 4-bit wrap.
- Simultaneous events: reset overrides start and the payload handshake. A start pulse arriving in the same cycle the block returns to IDLE is accepted only if busy=0 in that cycle.

Test Plan:
- Basic frame: dst=48'h010203040506, src=48'hFFFEFDFCFBFA, tl=16'h0800, 50 payload bytes (49x0x55, then 0x56 with pl_last) -> output is 7x55, D5, 01..06, FF..FA, 08, 00, the 50 payload bytes, then 4 FCS bytes matching the software CRC model. control is high 76 cycles, then 12 low; counter=1. Loopback into epd gives all *_valid=1 and valid_packet_counter=1.
- Short payload, 10 bytes -> 36 bytes of 0x00 padding; control high 72 cycles; FCS computed over the padded payload; counter increments.
- Underrun: pl_valid deasserted after 20 payload bytes -> control=0 the next cycle, tx_underrun pulses once, counter unchanged, busy held through 12 IFG cycles.
- Oversize: source offers 1600 bytes with no pl_last -> exactly 1500 transfers, pl_ready low afterwards, control high 1526 cycles, counter increments.
- Mid-frame reset: reset asserted while SRC bytes are on data -> next cycle data=0x00, control=0, busy=0, counter=0; a following start produces a correct full frame.
- Back-to-back: 16 frames with start held high -> each frame separated by exactly 12 IFG cycles, counter sequence 1..15 then wraps to 0; start pulses while busy are ignored.
